// File: rtl/timer_dev.sv
// timer_dev: programmable countdown timer on the processor I/O bus.
//
// Counts a loaded PRESET value down to zero, then raises a pending interrupt.
// One-shot mode clears EN after firing; auto-reload mode reloads PRESET and
// keeps running, giving a one-cycle irq pulse per period.
//
// Ports:
//   clk   in   system clock, all state updates on the rising edge
//   rst   in   synchronous active-high reset
//   addr  in   word select: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved
//   we    in   write strobe (already qualified by device select)
//   din   in   write data
//   dout  out  read data, combinational on addr
//   irq   out  level interrupt request = pend & IM
module timer_dev #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             irq
);

    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrPreset = 2'd1;
    localparam logic [1:0] AddrCount  = 2'd2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2,
        StInt  = 2'd3
    } state_e;

    state_e           r_state;
    logic [3:0]       r_ctrl;
    logic [WIDTH-1:0] r_preset;
    logic [WIDTH-1:0] r_count;
    logic             r_pend;

    state_e           w_state_next;
    logic [3:0]       w_ctrl_next;
    logic [WIDTH-1:0] w_preset_next;
    logic [WIDTH-1:0] w_count_next;
    logic             w_pend_next;

    logic w_en;
    logic w_im;
    logic w_auto;
    logic w_wr_ctrl;
    logic w_wr_preset;

    assign w_en        = r_ctrl[0];
    assign w_im        = r_ctrl[3];
    // Only MODE = 01 reloads; 10 and 11 fall back to one-shot.
    assign w_auto      = (r_ctrl[2:1] == 2'b01);
    assign w_wr_ctrl   = we && (addr == AddrCtrl);
    assign w_wr_preset = we && (addr == AddrPreset);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_ctrl   <= 4'd0;
            r_preset <= '0;
            r_count  <= '0;
            r_pend   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_ctrl   <= w_ctrl_next;
            r_preset <= w_preset_next;
            r_count  <= w_count_next;
            r_pend   <= w_pend_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_ctrl_next   = r_ctrl;
        w_preset_next = r_preset;
        w_count_next  = r_count;
        w_pend_next   = r_pend;

        case (r_state)
            StIdle: begin
                if (w_en) begin
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                w_count_next = r_preset;
                w_state_next = StCnt;
            end
            StCnt: begin
                if (!w_en) begin
                    w_state_next = StIdle;
                end else if (r_count == '0) begin
                    w_pend_next  = 1'b1;
                    w_state_next = StInt;
                end else begin
                    w_count_next = r_count - WIDTH'(1);
                end
            end
            StInt: begin
                if (w_auto) begin
                    w_pend_next  = 1'b0;
                    w_state_next = StLoad;
                end else begin
                    w_ctrl_next[0] = 1'b0;
                    w_state_next   = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase

        // A CTRL write overrides whatever the FSM decided this cycle and
        // freezes the count where it stands.
        if (w_wr_ctrl) begin
            w_ctrl_next  = din[3:0];
            w_pend_next  = 1'b0;
            w_state_next = StIdle;
            w_count_next = r_count;
        end

        // LOAD above reads r_preset, so a same-edge write only affects the next LOAD.
        if (w_wr_preset) begin
            w_preset_next = din;
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            AddrCtrl:   dout = {{(WIDTH - 4){1'b0}}, r_ctrl};
            AddrPreset: dout = r_preset;
            AddrCount:  dout = r_count;
            default:    dout = '0;
        endcase
    end

    assign irq = r_pend & w_im;

endmodule

// File: tb/tb_timer_dev.sv
module tb_timer_dev;

    logic        clk;
    logic        rst;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int total;
    int bad;

    timer_dev #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register write landing on the next rising edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int a = 0; a < 3; a++) begin
            addr = a[1:0];
            #1;
            total++;
            if (dout !== 32'd0) begin
                bad++;
                $display("FAIL reset_dout addr=%0d got=%h exp=%h", a, dout, 32'd0);
            end
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] exp_cnt;
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e >= 2 && e <= 7) begin
                exp_cnt = 32'(7 - e);
                addr = 2'd2;
                #1;
                total++;
                if (dout !== exp_cnt) begin
                    bad++;
                    $display("FAIL oneshot_count edge=%0d got=%0d exp=%0d", e, dout, exp_cnt);
                end
            end
            total++;
            if (irq !== (e >= 8)) begin
                bad++;
                $display("FAIL oneshot_irq edge=%0d got=%b exp=%b", e, irq, (e >= 8));
            end
            addr = 2'd0;
            #1;
            total++;
            if (dout !== ((e >= 9) ? 32'h8 : 32'h9)) begin
                bad++;
                $display("FAIL oneshot_ctrl edge=%0d got=%h exp=%h", e, dout,
                         (e >= 9) ? 32'h8 : 32'h9);
            end
        end
        wr(2'd0, 32'h0);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_irq_clear got=%b exp=0", irq);
        end
    endtask

    task automatic test_auto_reload();
        logic exp_irq;
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int e = 1; e <= 30; e++) begin
            tick();
            exp_irq = (e >= 6) && ((e - 6) % 6 == 0);
            total++;
            if (irq !== exp_irq) begin
                bad++;
                $display("FAIL auto_irq edge=%0d got=%b exp=%b", e, irq, exp_irq);
            end
        end
        wr(2'd0, 32'h0);
    endtask

    task automatic test_masked();
        logic [31:0] exp_ctrl;
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int e = 1; e <= 8; e++) begin
            tick();
            total++;
            if (irq !== 1'b0) begin
                bad++;
                $display("FAIL masked_irq edge=%0d got=%b exp=0", e, irq);
            end
            exp_ctrl = (e >= 6) ? 32'h0 : 32'h1;
            addr = 2'd0;
            #1;
            total++;
            if (dout !== exp_ctrl) begin
                bad++;
                $display("FAIL masked_ctrl edge=%0d got=%h exp=%h", e, dout, exp_ctrl);
            end
        end
    endtask

    task automatic test_abort();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        for (int e = 1; e <= 5; e++) tick();
        addr = 2'd2;
        #1;
        total++;
        if (dout !== 32'd7) begin
            bad++;
            $display("FAIL abort_count_before got=%0d exp=7", dout);
        end
        wr(2'd0, 32'h0);
        for (int e = 0; e < 6; e++) begin
            addr = 2'd2;
            #1;
            total++;
            if (dout !== 32'd7 || irq !== 1'b0) begin
                bad++;
                $display("FAIL abort_hold step=%0d got count=%0d irq=%b exp count=7 irq=0",
                         e, dout, irq);
            end
            tick();
        end
    endtask

    task automatic test_preset_zero();
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        for (int e = 1; e <= 5; e++) begin
            tick();
            total++;
            if (irq !== (e >= 3)) begin
                bad++;
                $display("FAIL preset0_irq edge=%0d got=%b exp=%b", e, irq, (e >= 3));
            end
        end
        wr(2'd0, 32'h0);
    endtask

    task automatic test_preset_collision();
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h1);
        tick();
        wr(2'd1, 32'd9);
        addr = 2'd2;
        #1;
        total++;
        if (dout !== 32'd4) begin
            bad++;
            $display("FAIL load_collision_count got=%0d exp=4", dout);
        end
        addr = 2'd1;
        #1;
        total++;
        if (dout !== 32'd9) begin
            bad++;
            $display("FAIL load_collision_preset got=%0d exp=9", dout);
        end
        wr(2'd0, 32'h0);
    endtask

    task automatic test_int_collision();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        for (int e = 1; e <= 4; e++) tick();
        // Edge 5 is the CNT->INT edge; restart through a CTRL write there.
        wr(2'd0, 32'h9);
        for (int e = 5; e <= 10; e++) begin
            total++;
            if (irq !== (e == 10)) begin
                bad++;
                $display("FAIL int_collision_irq edge=%0d got=%b exp=%b", e, irq, (e == 10));
            end
            if (e == 7) begin
                addr = 2'd2;
                #1;
                total++;
                if (dout !== 32'd2) begin
                    bad++;
                    $display("FAIL int_collision_reload got=%0d exp=2", dout);
                end
            end
            if (e < 10) tick();
        end
        wr(2'd0, 32'h0);
    endtask

    task automatic test_read_during_write();
        wr(2'd1, 32'h1234);
        addr = 2'd1;
        din  = 32'h5555;
        we   = 1'b1;
        #1;
        total++;
        if (dout !== 32'h1234) begin
            bad++;
            $display("FAIL rw_same_cycle got=%h exp=%h", dout, 32'h1234);
        end
        tick();
        we = 1'b0;
        total++;
        if (dout !== 32'h5555) begin
            bad++;
            $display("FAIL rw_after got=%h exp=%h", dout, 32'h5555);
        end
        addr = 2'd3;
        #1;
        total++;
        if (dout !== 32'd0) begin
            bad++;
            $display("FAIL reserved_read got=%h exp=0", dout);
        end
    endtask

    task automatic test_reset_mid_count();
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int e = 1; e <= 3; e++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int e = 0; e < 3; e++) begin
            for (int a = 0; a < 3; a++) begin
                addr = a[1:0];
                #1;
                total++;
                if (dout !== 32'd0) begin
                    bad++;
                    $display("FAIL midrst_dout step=%0d addr=%0d got=%h exp=0", e, a, dout);
                end
            end
            total++;
            if (irq !== 1'b0) begin
                bad++;
                $display("FAIL midrst_irq step=%0d got=%b exp=0", e, irq);
            end
            tick();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        addr  = 2'd0;
        we    = 1'b0;
        din   = 32'd0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_masked();
        test_abort();
        test_preset_zero();
        test_preset_collision();
        test_int_collision();
        test_read_during_write();
        test_reset_mid_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
